adc_sram_capture: RTL and testbench

- Sits between the three vco_adc sinc3 decimators and the two 32x512 SRAM macros.
- Selects one ADC channel and writes its decimated samples into the SRAMs as a ping-pong buffer: fills bank 0, then bank 1, then bank 0 again.
- Raises an interrupt each time a bank fills, so management firmware can drain that bank through the read port while the other bank fills.

---
 rtl/adc_capture_pkg.sv | 20 ++
 rtl/adc_ch_mux.sv | 31 +++
 rtl/adc_sram_capture.sv | 211 +++++++++++++++++++++
 tb/tb_adc_sram_capture.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_capture_pkg.sv
// Shared constants, FSM state type and channel-mapping helper for adc_sram_capture.
package adc_capture_pkg;

  localparam int unsigned ADDR_W    = 9;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned NUM_CH    = 3;
  localparam logic [3:0]  WMASK_ALL = 4'hF;

  typedef enum logic [1:0] {
    StIdle,
    StCapture,
    StStall
  } state_e;

  // Channel select value 3 has no channel behind it; it aliases channel 0.
  function automatic logic [1:0] map_ch(input logic [1:0] sel);
    return (sel == 2'd3) ? 2'd0 : sel;
  endfunction

endpackage

// File: rtl/adc_ch_mux.sv
// One-cycle registered select of the latched channel's strobe and sample.
module adc_ch_mux
  import adc_capture_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               ch_sel,
  input  logic [NUM_CH-1:0]        adc_dvalid,
  input  logic [NUM_CH*DATA_W-1:0] adc_dat,
  output logic                     sel_valid,
  output logic [DATA_W-1:0]        sel_dat
);

  logic [1:0] ch;

  assign ch = map_ch(ch_sel);

  // Register the selected strobe every cycle; data only updates on a strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_valid <= 1'b0;
      sel_dat   <= '0;
    end else begin
      sel_valid <= adc_dvalid[ch];
      if (adc_dvalid[ch]) begin
        sel_dat <= adc_dat[ch*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/adc_sram_capture.sv
// Ping-pong capture of one decimated ADC channel into two SRAM banks.
// Optional macro ADC_CAPTURE_DROPCNT_EN adds drop_cnt_o, a saturating count of
// samples dropped while both banks are full.
module adc_sram_capture
  import adc_capture_pkg::*;
(
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_ni,
  input  logic                     start_i,
  input  logic                     stop_i,
  input  logic [1:0]               ch_sel_i,
  input  logic [ADDR_W-1:0]        depth_i,
  input  logic [1:0]               bank_ack_i,
  input  logic [NUM_CH-1:0]        adc_dvalid_i,
  input  logic [NUM_CH*DATA_W-1:0] adc_dat_i,
  output logic [1:0]               mem_wenb_o,
  output logic [ADDR_W-1:0]        mem_waddr_o,
  output logic [DATA_W-1:0]        mem_data_o,
  output logic [3:0]               wmask_o,
  output logic [1:0]               bank_full_o,
  output logic                     active_bank_o,
  output logic [ADDR_W:0]          wcount_o,
  output logic                     irq_o,
  output logic                     overrun_o,
  output logic                     busy_o
`ifdef ADC_CAPTURE_DROPCNT_EN
  ,
  output logic [15:0]              drop_cnt_o
`endif
);

  state_e              state_q, state_d;
  state_e              prev_state_q;
  logic [1:0]          ch_q, ch_d;
  logic [ADDR_W-1:0]   depth_q, depth_d;
  logic                bank_q, bank_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     wcount_q, wcount_d;
  logic [1:0]          full_q, full_d;
  logic                overrun_q, overrun_d;
  logic                irq_q, irq_d;
  logic [1:0]          wen_q, wen_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic                sel_valid;
  logic [DATA_W-1:0]   sel_dat;
  logic                start_go;
  logic                do_write;
  logic                do_drop;
  logic                bank_done;

  adc_ch_mux u_ch_mux (
    .clk        (wb_clk_i),
    .rst_n      (wb_rst_ni),
    .ch_sel     (ch_q),
    .adc_dvalid (adc_dvalid_i),
    .adc_dat    (adc_dat_i),
    .sel_valid  (sel_valid),
    .sel_dat    (sel_dat)
  );

  // A sample's fate is decided by the state it was sampled in, so a write
  // registered just before stop_i still lands and STALL-time samples drop.
  assign start_go  = (state_q == StIdle) && start_i && !stop_i;
  assign do_write  = sel_valid && (prev_state_q == StCapture);
  assign do_drop   = sel_valid && (prev_state_q == StStall);
  assign bank_done = do_write && (addr_q == depth_q);

  // Next-state, bank bookkeeping and write-register staging.
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    depth_d   = depth_q;
    bank_d    = bank_q;
    addr_d    = addr_q;
    wcount_d  = wcount_q;
    full_d    = full_q & ~bank_ack_i;  // acks first so a same-cycle set wins
    overrun_d = overrun_q;
    irq_d     = 1'b0;
    wen_d     = 2'b00;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;

    if (do_write) begin
      wen_d[bank_q] = 1'b1;
      waddr_d       = addr_q;
      wdata_d       = sel_dat;
      wcount_d      = {1'b0, addr_q} + 1'b1;
      if (bank_done) begin
        full_d[bank_q] = 1'b1;
        irq_d          = 1'b1;
      end else begin
        addr_d = addr_q + 1'b1;
      end
    end

    if (do_drop) begin
      overrun_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (start_go) begin
          state_d   = StCapture;
          ch_d      = ch_sel_i;
          depth_d   = depth_i;
          bank_d    = 1'b0;
          addr_d    = '0;
          wcount_d  = '0;
          full_d    = 2'b00;
          overrun_d = 1'b0;
        end
      end
      StCapture: begin
        if (stop_i) begin
          state_d = StIdle;
        end else if (bank_done) begin
          if (!full_d[~bank_q]) begin
            bank_d   = ~bank_q;
            addr_d   = '0;
            wcount_d = '0;
          end else begin
            state_d = StStall;
          end
        end
      end
      StStall: begin
        if (stop_i) begin
          state_d = StIdle;
        end else if (!full_d[~bank_q]) begin
          state_d  = StCapture;
          bank_d   = ~bank_q;
          addr_d   = '0;
          wcount_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and write-port registers; reset forces the SRAM strobes inactive at once.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q      <= StIdle;
      prev_state_q <= StIdle;
      ch_q         <= 2'd0;
      depth_q      <= '0;
      bank_q       <= 1'b0;
      addr_q       <= '0;
      wcount_q     <= '0;
      full_q       <= 2'b00;
      overrun_q    <= 1'b0;
      irq_q        <= 1'b0;
      wen_q        <= 2'b00;
      waddr_q      <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      prev_state_q <= state_q;
      ch_q         <= ch_d;
      depth_q      <= depth_d;
      bank_q       <= bank_d;
      addr_q       <= addr_d;
      wcount_q     <= wcount_d;
      full_q       <= full_d;
      overrun_q    <= overrun_d;
      irq_q        <= irq_d;
      wen_q        <= wen_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
    end
  end

`ifdef ADC_CAPTURE_DROPCNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Saturating dropped-sample counter, cleared when a capture starts.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (start_go) begin
      drop_cnt_d = '0;
    end else if (do_drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  // Drop counter register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
`endif

  assign mem_wenb_o    = ~wen_q;
  assign mem_waddr_o   = waddr_q;
  assign mem_data_o    = wdata_q;
  assign wmask_o       = (|wen_q) ? WMASK_ALL : 4'h0;
  assign bank_full_o   = full_q;
  assign active_bank_o = bank_q;
  assign wcount_o      = wcount_q;
  assign irq_o         = irq_q;
  assign overrun_o     = overrun_q;
  assign busy_o        = (state_q != StIdle);

endmodule

// File: tb/tb_adc_sram_capture.sv
// Directed self-checking bench for adc_sram_capture.
module tb_adc_sram_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop;
  logic [1:0]  ch_sel;
  logic [8:0]  depth;
  logic [1:0]  bank_ack;
  logic [2:0]  adc_dvalid;
  logic [95:0] adc_dat;
  logic [1:0]  mem_wenb;
  logic [8:0]  mem_waddr;
  logic [31:0] mem_data;
  logic [3:0]  wmask;
  logic [1:0]  bank_full;
  logic        active_bank;
  logic [9:0]  wcount;
  logic        irq, overrun, busy;
`ifdef ADC_CAPTURE_DROPCNT_EN
  logic [15:0] drop_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adc_sram_capture dut (
    .wb_clk_i      (clk),
    .wb_rst_ni     (rst_n),
    .start_i       (start),
    .stop_i        (stop),
    .ch_sel_i      (ch_sel),
    .depth_i       (depth),
    .bank_ack_i    (bank_ack),
    .adc_dvalid_i  (adc_dvalid),
    .adc_dat_i     (adc_dat),
    .mem_wenb_o    (mem_wenb),
    .mem_waddr_o   (mem_waddr),
    .mem_data_o    (mem_data),
    .wmask_o       (wmask),
    .bank_full_o   (bank_full),
    .active_bank_o (active_bank),
    .wcount_o      (wcount),
    .irq_o         (irq),
    .overrun_o     (overrun),
    .busy_o        (busy)
`ifdef ADC_CAPTURE_DROPCNT_EN
    ,
    .drop_cnt_o    (drop_cnt)
`endif
  );

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse(input logic [1:0] ch, input logic [8:0] d);
    ch_sel = ch;
    depth  = d;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic stop_pulse();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  // One-cycle strobe on channel ch; returns just after the sampling edge.
  task automatic strobe(input int ch, input logic [31:0] data);
    adc_dat             = '0;
    adc_dat[ch*32 +: 32] = data;
    adc_dvalid          = '0;
    adc_dvalid[ch]      = 1'b1;
    tick();
    adc_dvalid          = '0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({mem_wenb, mem_waddr, mem_data, wmask} !== {2'b11, 9'd0, 32'd0, 4'h0}) begin
      errors++;
      $display("FAIL reset_wport: got %h expected %h", {mem_wenb, mem_waddr, mem_data, wmask},
               {2'b11, 9'd0, 32'd0, 4'h0});
    end
    checks++;
    if ({bank_full, active_bank, wcount, irq, overrun, busy} !== 16'd0) begin
      errors++;
      $display("FAIL reset_status: got %h expected %h",
               {bank_full, active_bank, wcount, irq, overrun, busy}, 16'd0);
    end
    #10 rst_n = 1'b1;
    tick();
  endtask

  // Fill bank 0 with four ch1 samples at depth 3.
  task automatic test_fill_bank0();
    start_pulse(2'd1, 9'd3);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL start_busy: got %b expected 1", busy);
    end
    for (int i = 0; i < 4; i++) begin
      strobe(1, 32'hA0 + i);
      tick();
      checks++;
      if ({mem_wenb, mem_waddr, mem_data, wmask, irq} !==
          {2'b10, 9'(i), 32'hA0 + 32'(i), 4'hF, (i == 3)}) begin
        errors++;
        $display("FAIL b0_write%0d: got %h expected %h", i,
                 {mem_wenb, mem_waddr, mem_data, wmask, irq},
                 {2'b10, 9'(i), 32'hA0 + 32'(i), 4'hF, (i == 3)});
      end
      checks++;
      if (wcount !== ((i == 3) ? 10'd0 : 10'(i + 1))) begin
        errors++;
        $display("FAIL b0_wcount%0d: got %0d expected %0d", i, wcount,
                 (i == 3) ? 0 : i + 1);
      end
      tick();
      checks++;
      if ({mem_wenb, wmask, irq} !== {2'b11, 4'h0, 1'b0}) begin
        errors++;
        $display("FAIL b0_idle%0d: got %h expected %h", i, {mem_wenb, wmask, irq},
                 {2'b11, 4'h0, 1'b0});
      end
    end
    checks++;
    if ({bank_full, active_bank, busy} !== {2'b01, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL b0_full: got %b expected %b", {bank_full, active_bank, busy},
               {2'b01, 1'b1, 1'b1});
    end
  endtask

  // Fill bank 1, stall, drop one sample, then ack bank 0 to resume.
  task automatic test_pingpong_stall();
    for (int i = 0; i < 4; i++) begin
      strobe(1, 32'hB0 + i);
      tick();
      checks++;
      if ({mem_wenb, mem_waddr, mem_data} !== {2'b01, 9'(i), 32'hB0 + 32'(i)}) begin
        errors++;
        $display("FAIL b1_write%0d: got %h expected %h", i, {mem_wenb, mem_waddr, mem_data},
                 {2'b01, 9'(i), 32'hB0 + 32'(i)});
      end
      tick();
    end
    checks++;
    if ({bank_full, active_bank, busy, overrun} !== {2'b11, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL stall_enter: got %b expected %b", {bank_full, active_bank, busy, overrun},
               {2'b11, 1'b1, 1'b1, 1'b0});
    end
    strobe(1, 32'hC0);
    tick();
    checks++;
    if ({mem_wenb, overrun} !== {2'b11, 1'b1}) begin
      errors++;
      $display("FAIL stall_drop: got %b expected %b", {mem_wenb, overrun}, {2'b11, 1'b1});
    end
`ifdef ADC_CAPTURE_DROPCNT_EN
    checks++;
    if (drop_cnt !== 16'd1) begin
      errors++;
      $display("FAIL drop_cnt: got %0d expected 1", drop_cnt);
    end
`endif
    bank_ack = 2'b01;
    tick();
    bank_ack = 2'b00;
    checks++;
    if ({bank_full, active_bank, wcount, busy} !== {2'b10, 1'b0, 10'd0, 1'b1}) begin
      errors++;
      $display("FAIL stall_exit: got %h expected %h", {bank_full, active_bank, wcount, busy},
               {2'b10, 1'b0, 10'd0, 1'b1});
    end
    strobe(1, 32'hD0);
    tick();
    checks++;
    if ({mem_wenb, mem_waddr, mem_data} !== {2'b10, 9'd0, 32'hD0}) begin
      errors++;
      $display("FAIL resume_write: got %h expected %h", {mem_wenb, mem_waddr, mem_data},
               {2'b10, 9'd0, 32'hD0});
    end
    tick();
    stop_pulse();
  endtask

  // ch_sel=3 aliases channel 0; other channels ignored.
  task automatic test_ch_remap();
    start_pulse(2'd3, 9'd3);
    checks++;
    if ({bank_full, overrun, active_bank, wcount} !== {2'b00, 1'b0, 1'b0, 10'd0}) begin
      errors++;
      $display("FAIL start_clear: got %h expected %h", {bank_full, overrun, active_bank, wcount},
               {2'b00, 1'b0, 1'b0, 10'd0});
    end
    strobe(2, 32'h22);
    tick();
    checks++;
    if (mem_wenb !== 2'b11) begin
      errors++;
      $display("FAIL remap_ch2_ignored: got %b expected 11", mem_wenb);
    end
    tick();
    strobe(0, 32'h10);
    tick();
    checks++;
    if ({mem_wenb, mem_waddr, mem_data} !== {2'b10, 9'd0, 32'h10}) begin
      errors++;
      $display("FAIL remap_ch0_write: got %h expected %h", {mem_wenb, mem_waddr, mem_data},
               {2'b10, 9'd0, 32'h10});
    end
    tick();
    strobe(1, 32'h11);
    tick();
    checks++;
    if (mem_wenb !== 2'b11) begin
      errors++;
      $display("FAIL remap_ch1_ignored: got %b expected 11", mem_wenb);
    end
    tick();
    strobe(0, 32'h12);
    tick();
    checks++;
    if ({mem_wenb, mem_waddr, mem_data, wcount} !== {2'b10, 9'd1, 32'h12, 10'd2}) begin
      errors++;
      $display("FAIL remap_ch0_write2: got %h expected %h",
               {mem_wenb, mem_waddr, mem_data, wcount}, {2'b10, 9'd1, 32'h12, 10'd2});
    end
    tick();
  endtask

  // Stop in the same cycle as a strobe: the sample still lands.
  task automatic test_stop_with_dvalid();
    adc_dat       = '0;
    adc_dat[31:0] = 32'h13;
    adc_dvalid    = 3'b001;
    stop          = 1'b1;
    tick();
    adc_dvalid    = '0;
    stop          = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL stop_busy: got %b expected 0", busy);
    end
    tick();
    checks++;
    if ({mem_wenb, mem_waddr, mem_data, wcount, busy} !==
        {2'b10, 9'd2, 32'h13, 10'd3, 1'b0}) begin
      errors++;
      $display("FAIL stop_write: got %h expected %h",
               {mem_wenb, mem_waddr, mem_data, wcount, busy}, {2'b10, 9'd2, 32'h13, 10'd3, 1'b0});
    end
    tick();
    checks++;
    if ({mem_wenb, wcount} !== {2'b11, 10'd3}) begin
      errors++;
      $display("FAIL stop_hold: got %h expected %h", {mem_wenb, wcount}, {2'b11, 10'd3});
    end
  endtask

  // Ack of bank 0 in the very cycle it fills (depth 0): the set wins.
  task automatic test_ack_same_cycle();
    start_pulse(2'd1, 9'd0);
    strobe(1, 32'h55);
    bank_ack = 2'b01;
    tick();
    bank_ack = 2'b00;
    checks++;
    if ({mem_wenb, mem_waddr, bank_full, irq, active_bank} !==
        {2'b10, 9'd0, 2'b01, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL ack_vs_set: got %h expected %h",
               {mem_wenb, mem_waddr, bank_full, irq, active_bank},
               {2'b10, 9'd0, 2'b01, 1'b1, 1'b1});
    end
    tick();
    checks++;
    if ({bank_full, irq} !== {2'b01, 1'b0}) begin
      errors++;
      $display("FAIL ack_vs_set_hold: got %b expected %b", {bank_full, irq}, {2'b01, 1'b0});
    end
    stop_pulse();
  endtask

  // Asynchronous reset in the middle of a write cycle.
  task automatic test_reset_midwrite();
    start_pulse(2'd1, 9'd3);
    strobe(1, 32'h77);
    tick();
    checks++;
    if ({mem_wenb, mem_data} !== {2'b10, 32'h77}) begin
      errors++;
      $display("FAIL midwrite_pre: got %h expected %h", {mem_wenb, mem_data}, {2'b10, 32'h77});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_wenb, mem_waddr, mem_data, wmask} !== {2'b11, 9'd0, 32'd0, 4'h0}) begin
      errors++;
      $display("FAIL midwrite_wport: got %h expected %h", {mem_wenb, mem_waddr, mem_data, wmask},
               {2'b11, 9'd0, 32'd0, 4'h0});
    end
    checks++;
    if ({bank_full, active_bank, wcount, irq, overrun, busy} !== 16'd0) begin
      errors++;
      $display("FAIL midwrite_status: got %h expected %h",
               {bank_full, active_bank, wcount, irq, overrun, busy}, 16'd0);
    end
    #2 rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    ch_sel     = 2'd0;
    depth      = '0;
    bank_ack   = 2'b00;
    adc_dvalid = '0;
    adc_dat    = '0;
    test_reset();
    test_fill_bank0();
    test_pingpong_stall();
    test_ch_remap();
    test_stop_with_dvalid();
    test_ack_same_cycle();
    test_reset_midwrite();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
